inv_sub_bytes_seq: RTL and testbench

- Iterative AES InvSubBytes unit for the decryption datapath; the inverse of the encryption-side SubBytes stage.
- Substitutes each of the 16 bytes of a 128-bit state through the AES inverse S-box.
- Processes BYTES_PER_CYCLE bytes per clock, using that many shared inverse S-box lookups, to trade latency for area.
- Sits between inverse ShiftRows and AddRoundKey in the decrypt round controller, with valid/ready handshakes on both sides.

---
 rtl/inv_sub_bytes_seq.sv | 151 +++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: substitutes a 128-bit state through the inverse
// S-box, BYTES_PER_CYCLE bytes per clock, MSB chunk first.
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_data,
  input  logic         i_clear,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data,
  output logic         o_busy
);

  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int W  = 8 * BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [127:0]   work;
  logic [6:0]     chunk_lsb;
  logic [W-1:0]   cur_chunk;
  logic [W-1:0]   sub_chunk;
  logic           last_chunk;

  // FIPS-197 inverse S-box as a case ROM.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    case (x)
      8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5; 8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
      8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e; 8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
      8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82; 8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
      8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44; 8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
      8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32; 8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
      8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b; 8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
      8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66; 8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
      8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49; 8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
      8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64; 8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
      8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc; 8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
      8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50; 8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
      8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57; 8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
      8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00; 8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
      8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05; 8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
      8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f; 8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
      8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03; 8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
      8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41; 8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
      8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce; 8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
      8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22; 8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
      8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8; 8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
      8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71; 8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
      8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e; 8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
      8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b; 8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
      8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe; 8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
      8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33; 8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
      8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59; 8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
      8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9; 8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
      8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f; 8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
      8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d; 8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
      8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c; 8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
      8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e; 8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
      8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63; 8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
      default: y = 8'h00;
    endcase
    return y;
  endfunction

  // Chunk k sits at bit offset 128-(k+1)*W, so chunk 0 is the top W bits.
  assign chunk_lsb  = 7'(128 - (int'(cnt) + 1) * W);
  assign last_chunk = (cnt == CW'(N - 1));
  assign o_data     = work;

  // Chunk mux feeding BYTES_PER_CYCLE parallel inverse S-box lookups.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    sub_chunk = '0;
    cur_chunk = work[chunk_lsb +: W];
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      sub_chunk[j*8 +: 8] = inv_sbox(cur_chunk[j*8 +: 8]);
    end
  end

  // Control FSM, chunk counter, work register and registered handshake outputs.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      work    <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else if (i_clear) begin
      // Abort leaves the work register as-is; only control returns to IDLE.
      state   <= IDLE;
      cnt     <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            work    <= i_data;
            cnt     <= '0;
            state   <= BUSY;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
          end
        end
        BUSY: begin
          work[chunk_lsb +: W] <= sub_chunk;
          if (last_chunk) begin
            cnt     <= '0;
            state   <= DONE;
            o_busy  <= 1'b0;
            o_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq: four instances (4, 1, 8, 16 bytes
// per cycle) compared each cycle against a GF(2^8)-derived reference model.
module tb_inv_sub_bytes_seq;

  function automatic int bpc_of(input int g);
    case (g)
      0: return 4;
      1: return 1;
      2: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int n_of(input int g);
    return 16 / bpc_of(g);
  endfunction

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         clear = 1'b0;
  logic         valid_a   [4];
  logic         ready_a   [4];
  logic [127:0] data_a    [4];
  logic         o_ready_a [4];
  logic         o_valid_a [4];
  logic         o_busy_a  [4];
  logic [127:0] o_data_a  [4];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sb     [256];
  logic [7:0]   inv_sb [256];
  int           phase  [4] = '{default: 0};
  logic [127:0] exp_q  [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(bpc_of(g))) u_dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_valid (valid_a[g]),
      .o_ready (o_ready_a[g]),
      .i_data  (data_a[g]),
      .i_clear (clear),
      .o_valid (o_valid_a[g]),
      .i_ready (ready_a[g]),
      .o_data  (o_data_a[g]),
      .o_busy  (o_busy_a[g])
    );
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference S-box built from field arithmetic, independent of any table.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sb[x]     = s;
      inv_sb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] inv_sub(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv_sb[v[i*8 +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] fwd_sub(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = sb[v[i*8 +: 8]];
    return r;
  endfunction

  // Transaction model: phase 0 idle, 1..N substituting, N+1 holding result.
  always @(posedge clk or negedge n_rst) begin
    for (int d = 0; d < 4; d++) begin
      if (!n_rst)                   phase[d] <= 0;
      else if (clear)               phase[d] <= 0;
      else if (phase[d] == 0) begin
        if (valid_a[d]) begin
          phase[d] <= 1;
          exp_q[d] <= inv_sub(data_a[d]);
        end
      end
      else if (phase[d] <= n_of(d)) phase[d] <= phase[d] + 1;
      else if (ready_a[d])          phase[d] <= 0;
    end
  end

  // Compare every instance against the model mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      check($sformatf("d%0d_ready", d), 128'(o_ready_a[d]), 128'(phase[d] == 0));
      check($sformatf("d%0d_busy", d),  128'(o_busy_a[d]),  128'(phase[d] >= 1 && phase[d] <= n_of(d)));
      check($sformatf("d%0d_valid", d), 128'(o_valid_a[d]), 128'(phase[d] == n_of(d) + 1));
      if (phase[d] == n_of(d) + 1) check($sformatf("d%0d_data", d), o_data_a[d], exp_q[d]);
    end
  end

  task automatic run_block(input int d, input logic [127:0] din, output int edges,
                           output logic [127:0] dout);
    data_a[d]  = din;
    valid_a[d] = 1'b1;
    @(posedge clk); #1;
    valid_a[d] = 1'b0;
    edges = 1;
    while (!o_valid_a[d] && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!o_valid_a[d]) check($sformatf("d%0d_timeout", d), 128'd0, 128'd1);
    dout = o_data_a[d];
    if (ready_a[d]) begin
      @(posedge clk); #1;
      check($sformatf("d%0d_ready_after_hs", d), 128'(o_ready_a[d]), 128'd1);
    end
  endtask

  initial begin
    int           lat;
    logic [127:0] dout, held, din;

    for (int d = 0; d < 4; d++) begin
      valid_a[d] = 1'b0;
      ready_a[d] = 1'b1;
      data_a[d]  = '0;
    end
    build_tables();

    // Pin the reference model to known FIPS-197 entries.
    check("model_inv_00", 128'(inv_sb[8'h00]), 128'h52);
    check("model_inv_63", 128'(inv_sb[8'h63]), 128'h00);
    check("model_inv_7c", 128'(inv_sb[8'h7c]), 128'h01);
    check("model_inv_16", 128'(inv_sb[8'h16]), 128'hff);
    check("model_inv_ed", 128'(inv_sb[8'hed]), 128'h53);

    #2 n_rst = 1'b0;
    #20 n_rst = 1'b1;
    check("rst_data",  o_data_a[0], 128'h0);
    check("rst_ready", 128'(o_ready_a[0]), 128'd1);
    check("rst_valid", 128'(o_valid_a[0]), 128'd0);
    check("rst_busy",  128'(o_busy_a[0]), 128'd0);

    // Basic vectors, latency and random round-trip for every width.
    for (int d = 0; d < 4; d++) begin
      run_block(d, {16{8'h63}}, lat, dout);
      check($sformatf("d%0d_lat", d), 128'(lat), 128'(n_of(d) + 1));
      check($sformatf("d%0d_all63", d), dout, 128'h0);
      run_block(d, {4{32'h7C0016ED}}, lat, dout);
      check($sformatf("d%0d_anchor", d), dout, {4{32'h0152FF53}});
      for (int i = 0; i < ((d == 0) ? 1000 : 100); i++) begin
        din = {$urandom, $urandom, $urandom, $urandom};
        run_block(d, din, lat, dout);
        check($sformatf("d%0d_roundtrip", d), fwd_sub(dout), din);
      end
    end

    // Backpressure: result held, new input ignored.
    ready_a[0] = 1'b0;
    run_block(0, {16{8'hed}}, lat, held);
    check("bp_value", held, {16{8'h53}});
    for (int i = 0; i < 10; i++) begin
      valid_a[0] = 1'b1;
      data_a[0]  = {16{8'h00}};
      @(posedge clk); #1;
      check("bp_valid", 128'(o_valid_a[0]), 128'd1);
      check("bp_ready", 128'(o_ready_a[0]), 128'd0);
      check("bp_data",  o_data_a[0], held);
    end
    valid_a[0] = 1'b0;
    ready_a[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 128'(o_ready_a[0]), 128'd1);
    check("bp_release_valid", 128'(o_valid_a[0]), 128'd0);
    @(posedge clk); #1;
    check("bp_no_accept", 128'(o_busy_a[0]), 128'd0);

    // Asynchronous reset mid-BUSY.
    data_a[0]  = {16{8'h16}};
    valid_a[0] = 1'b1;
    @(posedge clk); #1;
    valid_a[0] = 1'b0;
    #3 n_rst = 1'b0;
    #1;
    check("arst_valid", 128'(o_valid_a[0]), 128'd0);
    check("arst_ready", 128'(o_ready_a[0]), 128'd1);
    check("arst_busy",  128'(o_busy_a[0]), 128'd0);
    check("arst_data",  o_data_a[0], 128'h0);
    #2 n_rst = 1'b1;
    @(posedge clk); #1;
    run_block(0, {16{8'h7c}}, lat, dout);
    check("arst_fresh", dout, {16{8'h01}});

    // Synchronous clear during BUSY.
    data_a[0]  = {16{8'h63}};
    valid_a[0] = 1'b1;
    @(posedge clk); #1;
    valid_a[0] = 1'b0;
    clear      = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_busy_ready", 128'(o_ready_a[0]), 128'd1);
    check("clr_busy_valid", 128'(o_valid_a[0]), 128'd0);
    check("clr_busy_busy",  128'(o_busy_a[0]), 128'd0);

    // Synchronous clear during DONE keeps o_data.
    ready_a[0] = 1'b0;
    run_block(0, {16{8'h16}}, lat, held);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    ready_a[0] = 1'b1;
    check("clr_done_valid", 128'(o_valid_a[0]), 128'd0);
    check("clr_done_ready", 128'(o_ready_a[0]), 128'd1);
    check("clr_done_data",  o_data_a[0], {16{8'hff}});
    run_block(0, {16{8'h00}}, lat, dout);
    check("clr_next_data", dout, {16{8'h52}});
    check("clr_next_lat",  128'(lat), 128'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
